// File: rtl/ppu_oam_dma.sv
// rtl/ppu_oam_dma.sv - $4014 sprite DMA: halts the CPU and copies one CPU page into primary OAM
module ppu_oam_dma #(
    parameter int N_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cen,
    input  logic        reg_wr,
    input  logic [7:0]  reg_data,
    input  logic [7:0]  oam_base,
    output logic        cpu_halt,
    output logic        dma_rd,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_data_in,
    output logic        oam_wr,
    output logic [7:0]  oam_wr_addr,
    output logic [7:0]  oam_wr_data,
    output logic        busy,
    output logic        done
);

    localparam int IW = $clog2(N_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t        state, state_nx;
    logic          par;
    logic [IW-1:0] idx, idx_nx;
    logic [7:0]    page, page_nx;
    logic [7:0]    base, base_nx;
    logic [7:0]    latch, latch_nx;
    logic          done_nx;
    logic [7:0]    idx8;

    assign idx8 = 8'(idx);

    // CPU-cycle parity: 0 = get (read) cycle, 1 = put (write) cycle; free-running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par <= 1'b0;
        end else if (cpu_cen) begin
            par <= ~par;
        end
    end

    // State, transfer context and data latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            page  <= 8'h00;
            base  <= 8'h00;
            latch <= 8'h00;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            page  <= page_nx;
            base  <= base_nx;
            latch <= latch_nx;
            done  <= done_nx;
        end
    end

    // Next-state logic; everything holds on clk edges without cpu_cen
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        page_nx  = page;
        base_nx  = base;
        latch_nx = latch;
        done_nx  = 1'b0;
        if (cpu_cen) begin
            case (state)
                S_IDLE: begin
                    if (reg_wr) begin
                        page_nx  = reg_data;
                        base_nx  = oam_base;
                        idx_nx   = '0;
                        state_nx = S_HALT;
                    end
                end
                // The cycle after HALT has parity ~par; reads must land on parity 0
                S_HALT:  state_nx = par ? S_READ : S_ALIGN;
                S_ALIGN: state_nx = S_READ;
                S_READ: begin
                    latch_nx = dma_data_in;
                    state_nx = S_WRITE;
                end
                S_WRITE: begin
                    if (idx == IW'(N_BYTES - 1)) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        idx_nx   = idx + IW'(1);
                        state_nx = S_READ;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from state; the OAM strobe is narrowed to the cpu_cen clk
    always_comb begin
        busy        = (state != S_IDLE);
        cpu_halt    = busy;
        dma_rd      = (state == S_READ);
        dma_addr    = dma_rd ? {page, idx8} : 16'h0000;
        oam_wr      = (state == S_WRITE) && cpu_cen;
        oam_wr_addr = (state == S_WRITE) ? (base + idx8) : 8'h00;
        oam_wr_data = (state == S_WRITE) ? latch : 8'h00;
    end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// tb/tb_ppu_oam_dma.sv - directed self-checking bench for ppu_oam_dma
module tb_ppu_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_cen;
    logic        reg_wr;
    logic [7:0]  reg_data;
    logic [7:0]  oam_base;
    logic        cpu_halt;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_in;
    logic        oam_wr;
    logic [7:0]  oam_wr_addr;
    logic [7:0]  oam_wr_data;
    logic        busy;
    logic        done;

    ppu_oam_dma #(.N_BYTES(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_cen     (cpu_cen),
        .reg_wr      (reg_wr),
        .reg_data    (reg_data),
        .oam_base    (oam_base),
        .cpu_halt    (cpu_halt),
        .dma_rd      (dma_rd),
        .dma_addr    (dma_addr),
        .dma_data_in (dma_data_in),
        .oam_wr      (oam_wr),
        .oam_wr_addr (oam_wr_addr),
        .oam_wr_data (oam_wr_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       tb_par;
    logic       jitter;
    logic [7:0] cur_page;
    int         cyc, halt_cnt, wr_cnt, done_cnt, first_rd, bad_page;
    logic [7:0] first_addr, first_data, addr17, data17, last_addr;
    logic [7:0] oam [256];
    logic       wrote [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CPU memory: page $02 holds i^$A5, other pages are scrambled by page number
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [7:0] h;
        h = a[15:8] ^ 8'h02;
        return a[7:0] ^ 8'hA5 ^ {h[3:0], h[3:0]};
    endfunction

    task automatic sample();
        if (cpu_cen) begin
            cyc++;
            if (cpu_halt) halt_cnt++;
            if (dma_rd && first_rd == 0) first_rd = cyc;
            if (dma_rd && dma_addr[15:8] != cur_page) bad_page++;
        end
        if (oam_wr) begin
            if (wr_cnt == 0) begin
                first_addr = oam_wr_addr;
                first_data = oam_wr_data;
            end
            if (wr_cnt == 16) begin
                addr17 = oam_wr_addr;
                data17 = oam_wr_data;
            end
            last_addr = oam_wr_addr;
            oam[oam_wr_addr]   = oam_wr_data;
            wrote[oam_wr_addr] = 1'b1;
            wr_cnt++;
        end
        if (done) done_cnt++;
    endtask

    task automatic tick(input logic cen, input logic wr, input logic [7:0] d);
        cpu_cen     = cen;
        reg_wr      = wr;
        reg_data    = d;
        dma_data_in = mem_byte(dma_addr);
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_cycle(input logic wr, input logic [7:0] d);
        int g;
        g = jitter ? int'($urandom_range(13, 9)) : 1;
        repeat (g) tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, wr, d);
        tb_par  = ~tb_par;
        cpu_cen = 1'b0;
        reg_wr  = 1'b0;
    endtask

    task automatic run(input logic [7:0] page, input logic [7:0] base, input logic p,
                       input int stop_at, input logic inject);
        int n;
        logic sent;
        while (tb_par != p) cpu_cycle(1'b0, 8'h00);
        cyc = 0; halt_cnt = 0; wr_cnt = 0; done_cnt = 0; first_rd = 0; bad_page = 0;
        for (int i = 0; i < 256; i++) wrote[i] = 1'b0;
        cur_page = page;
        oam_base = base;
        cpu_cycle(1'b1, page);
        oam_base = ~base;
        n = 0;
        sent = 1'b0;
        while (done_cnt == 0 && n < 2000 && !(stop_at >= 0 && wr_cnt >= stop_at)) begin
            if (inject && !sent && wr_cnt == 100) begin
                cpu_cycle(1'b1, 8'h07);
                sent = 1'b1;
            end else begin
                cpu_cycle(1'b0, 8'h00);
            end
            n++;
        end
        check("run_in_budget", 32'(n < 2000), 32'd1);
    endtask

    task automatic check_full(input string t, input logic [7:0] page, input logic [7:0] base,
                              input int exp_halt, input int exp_rd);
        int errs;
        logic [7:0] a;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            a = base + 8'(i);
            if (!wrote[a] || oam[a] !== mem_byte({page, 8'(i)})) errs++;
        end
        check({t, "_halt_cycles"}, halt_cnt, exp_halt);
        check({t, "_oam_writes"}, wr_cnt, 256);
        check({t, "_done_pulses"}, done_cnt, 1);
        check({t, "_first_rd_cycle"}, first_rd, exp_rd);
        check({t, "_bad_page_reads"}, bad_page, 0);
        check({t, "_oam_errors"}, errs, 0);
        cpu_cycle(1'b0, 8'h00);
        cpu_cycle(1'b0, 8'h00);
        check({t, "_busy_after"}, {31'd0, busy}, 0);
        check({t, "_done_once"}, done_cnt, 1);
    endtask

    initial begin
        reset = 1'b1; cpu_cen = 1'b0; reg_wr = 1'b0; reg_data = 8'h00;
        oam_base = 8'h00; dma_data_in = 8'h00; jitter = 1'b0; tb_par = 1'b0;
        cur_page = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {cpu_halt, dma_rd, dma_addr, oam_wr, oam_wr_addr,
                                oam_wr_data, busy, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: page $02 on a get cycle
        run(8'h02, 8'h00, 1'b0, -1, 1'b0);
        check_full("t1", 8'h02, 8'h00, 513, 3);

        // 2: same write on a put cycle needs the alignment cycle
        run(8'h02, 8'h00, 1'b1, -1, 1'b0);
        check_full("t2", 8'h02, 8'h00, 514, 4);

        // 3: OAMADDR wrap from $F0
        run(8'h03, 8'hF0, 1'b0, -1, 1'b0);
        check("t3_first_addr", first_addr, 8'hF0);
        check("t3_first_data", first_data, mem_byte(16'h0300));
        check("t3_addr17", addr17, 8'h00);
        check("t3_data17", data17, mem_byte(16'h0310));
        check("t3_last_addr", last_addr, 8'hEF);
        check_full("t3", 8'h03, 8'hF0, 513, 3);

        // 4: a second $4014 write during the transfer is ignored
        run(8'h03, 8'h20, 1'b1, -1, 1'b1);
        check_full("t4", 8'h03, 8'h20, 514, 4);

        // 5: reset in the middle of write #40
        run(8'h02, 8'h00, 1'b0, 39, 1'b0);
        cpu_cycle(1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        cpu_cen = 1'b1;
        #1;
        check("t5_wr_before_reset", {31'd0, oam_wr}, 1);
        reset = 1'b1;
        #1;
        check("t5_halt_async", {31'd0, cpu_halt}, 0);
        check("t5_oam_wr_async", {31'd0, oam_wr}, 0);
        check("t5_no_done", {31'd0, done}, 0);
        check("t5_writes_before", wr_cnt, 39);
        check("t5_done_cnt", done_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_cen = 1'b0;
        tb_par = 1'b0;
        run(8'h02, 8'h00, 1'b1, -1, 1'b0);
        check_full("t5", 8'h02, 8'h00, 514, 4);
        run(8'h02, 8'h00, 1'b0, -1, 1'b0);
        check_full("t5b", 8'h02, 8'h00, 513, 3);

        // 6: sparse, jittered cpu_cen
        jitter = 1'b1;
        run(8'h02, 8'h00, 1'b0, -1, 1'b0);
        check_full("t6", 8'h02, 8'h00, 513, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
